// File: rtl/vscale_lsu_pkg.sv
// vscale_lsu_pkg: shared control constants for the load/store unit.
//   - RV funct3 memory encodings (LB..LWU)
//   - dmem_size codes (byte/half/word/dword)
//   - LSU state encodings (IDLE/DATA/ERR)
package vscale_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_DATA = 2'd1,
    LSU_ERR  = 2'd2
  } lsu_state_e;

  // Bus size code is the low two funct3 bits; bit 2 only selects zero-extension.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    return {1'b0, f3[1:0]};
  endfunction

endpackage

// File: rtl/vscale_lsu_align.sv
// vscale_lsu_align: combinational data-path alignment for the LSU.
//   Load side : shifts dmem read data down by the byte lane, selects
//               byte/half/word/dword and sign- or zero-extends to XLEN.
//   Store side: replicates right-aligned store data across every lane of
//               its size so the memory can pick the lanes by byte enables.
// Ports:
//   ld_funct3 - funct3 of the load being completed
//   ld_lane   - byte offset of the load within the XLEN word
//   rdata     - raw data-phase read data
//   ld_data   - extended load result
//   st_size   - size code of the store (0 byte .. 3 dword)
//   st_wdata  - right-aligned store data
//   st_data   - lane-replicated store data
module vscale_lsu_align
  import vscale_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0] ld_lane,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN-1:0]           ld_data,
  input  logic [1:0]                st_size,
  input  logic [XLEN-1:0]           st_wdata,
  output logic [XLEN-1:0]           st_data
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {ld_lane, 3'b000};

  // Size casts of signed operands sign-extend; unsigned operands zero-extend.
  always_comb begin
    ld_data = '0;
    case (ld_funct3)
      F3_LB:   ld_data = XLEN'($signed(sh[7:0]));
      F3_LH:   ld_data = XLEN'($signed(sh[15:0]));
      F3_LW:   ld_data = XLEN'($signed(sh[31:0]));
      F3_LD:   ld_data = sh;
      F3_LBU:  ld_data = XLEN'(sh[7:0]);
      F3_LHU:  ld_data = XLEN'(sh[15:0]);
      F3_LWU:  ld_data = XLEN'(sh[31:0]);
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    st_data = st_wdata;
    case (st_size)
      2'b00:   st_data = {(XLEN/8){st_wdata[7:0]}};
      2'b01:   st_data = {(XLEN/16){st_wdata[15:0]}};
      2'b10:   st_data = {(XLEN/32){st_wdata[31:0]}};
      default: st_data = st_wdata;
    endcase
  end

endmodule

// File: rtl/vscale_lsu.sv
// vscale_lsu: load/store unit between execute and a pipelined dmem port
// (address phase, then data phase). One response per accepted request.
// Optional macro VSCALE_LSU_PERF_EN adds saturating perf counters.
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   req_*                 - execute-stage request (valid/ready handshake)
//   kill                  - squash: blocks acceptance, drops pending load resp
//   dmem_en/wen/size/addr - address phase (combinational from req_*)
//   dmem_wdata_delayed    - data-phase store data, lane-replicated
//   dmem_rdata/wait/badmem_e - data-phase return
//   resp_*                - one-cycle response to writeback
//   busy                  - access or error response outstanding
//   perf_* (macro only)   - load/store/wait-cycle counters
module vscale_lsu
  import vscale_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic              kill,
  output logic              dmem_en,
  output logic              dmem_wen,
  output logic [2:0]        dmem_size,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata_delayed,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_wait,
  input  logic              dmem_badmem_e,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_fault,
`ifdef VSCALE_LSU_PERF_EN
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_wait_cycles,
`endif
  output logic              busy
);

  localparam int LANE_W = $clog2(XLEN/8);

  lsu_state_e        state, state_nxt;
  logic              wen_q, killed_q, err_mis_q, err_fault_q;
  logic [2:0]        f3_q;
  logic [LANE_W-1:0] lane_q;
  logic [XLEN-1:0]   wdata_q;

  logic              illegal, misaligned, accept, go, done, load_killed, resp_ok;
  logic [XLEN-1:0]   ld_data, st_data;

  // D and WU need a 64-bit datapath; funct3 111 is never a memory op.
  assign illegal = (req_funct3 == 3'b111) ||
                   ((XLEN == 32) && ((req_funct3 == F3_LD) || (req_funct3 == F3_LWU)));

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign done        = (state == LSU_DATA) && !dmem_wait;
  // A kill landing on the completion cycle still drops a load.
  assign load_killed = !wen_q && (killed_q || kill);
  assign resp_ok     = done && !load_killed;

  assign req_ready = reset_n && !kill && ((state == LSU_IDLE) || done);
  assign accept    = req_valid && req_ready;
  assign go        = accept && !illegal && !misaligned;

  vscale_lsu_align #(.XLEN(XLEN)) u_align (
    .ld_funct3 (f3_q),
    .ld_lane   (lane_q),
    .rdata     (dmem_rdata),
    .ld_data   (ld_data),
    .st_size   (req_funct3[1:0]),
    .st_wdata  (req_wdata),
    .st_data   (st_data)
  );

  // Address phase
  assign dmem_en   = go;
  assign dmem_wen  = go && req_wen;
  assign dmem_size = go ? f3_size(req_funct3) : SIZE_BYTE;
  assign dmem_addr = go ? req_addr : '0;

  // Data phase and response; reset forces every output low.
  assign dmem_wdata_delayed = (reset_n && (state == LSU_DATA) && wen_q) ? wdata_q : '0;
  assign resp_valid      = reset_n && (resp_ok || (state == LSU_ERR));
  assign resp_rdata      = (reset_n && resp_ok && !wen_q) ? ld_data : '0;
  assign resp_fault      = reset_n && ((resp_ok && dmem_badmem_e) ||
                                       ((state == LSU_ERR) && err_fault_q));
  assign resp_misaligned = reset_n && (state == LSU_ERR) && err_mis_q;
  assign busy            = reset_n && (state != LSU_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (accept) state_nxt = go ? LSU_DATA : LSU_ERR;
      LSU_DATA: if (!dmem_wait) begin
        if (accept) state_nxt = go ? LSU_DATA : LSU_ERR;
        else        state_nxt = LSU_IDLE;
      end
      LSU_ERR:  state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= LSU_IDLE;
      wen_q       <= 1'b0;
      killed_q    <= 1'b0;
      err_mis_q   <= 1'b0;
      err_fault_q <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        err_mis_q   <= misaligned && !illegal;
        err_fault_q <= illegal;
      end
      if (go) begin
        wen_q    <= req_wen;
        f3_q     <= req_funct3;
        lane_q   <= req_addr[LANE_W-1:0];
        wdata_q  <= st_data;
        killed_q <= 1'b0;
      end else if ((state == LSU_DATA) && kill && !wen_q) begin
        killed_q <= 1'b1;
      end
    end
  end

`ifdef VSCALE_LSU_PERF_EN
  logic load_ok, store_ok;
  assign load_ok  = resp_ok && !wen_q && !dmem_badmem_e;
  assign store_ok = resp_ok &&  wen_q && !dmem_badmem_e;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_loads       <= '0;
      perf_stores      <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (load_ok  && (perf_loads  != '1)) perf_loads  <= perf_loads + 32'd1;
      if (store_ok && (perf_stores != '1)) perf_stores <= perf_stores + 32'd1;
      if ((state == LSU_DATA) && dmem_wait && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_lsu.sv
// Bench for vscale_lsu: one XLEN=32 and one XLEN=64 instance on shared
// stimulus; directed scenarios plus a randomized run against a
// byte-arithmetic reference model.
module tb_vscale_lsu;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, kill = 1'b0;
  logic        dmem_wait = 1'b0, dmem_badmem_e = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, dmem_rdata = '0;

  logic        a_ready, a_en, a_wen, a_rv, a_mis, a_flt, a_busy;
  logic [2:0]  a_size;
  logic [31:0] a_addr, a_wdd, a_rd;
  logic        b_ready, b_en, b_wen, b_rv, b_mis, b_flt, b_busy;
  logic [2:0]  b_size;
  logic [31:0] b_addr;
  logic [63:0] b_wdd, b_rd;

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  vscale_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(a_ready),
    .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .kill(kill), .dmem_en(a_en), .dmem_wen(a_wen),
    .dmem_size(a_size), .dmem_addr(a_addr), .dmem_wdata_delayed(a_wdd),
    .dmem_rdata(dmem_rdata[31:0]), .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
    .resp_valid(a_rv), .resp_rdata(a_rd), .resp_misaligned(a_mis),
    .resp_fault(a_flt), .busy(a_busy));

  vscale_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(b_ready),
    .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .kill(kill), .dmem_en(b_en), .dmem_wen(b_wen),
    .dmem_size(b_size), .dmem_addr(b_addr), .dmem_wdata_delayed(b_wdd),
    .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
    .resp_valid(b_rv), .resp_rdata(b_rd), .resp_misaligned(b_mis),
    .resp_fault(b_flt), .busy(b_busy));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int m_sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_ill(input int xlen, input logic [2:0] f3);
    return (f3 == 3'd7) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6));
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % m_sz(f3)) != 0;
  endfunction

  function automatic logic [63:0] m_load(input int xlen, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [63:0] rd);
    int sz = m_sz(f3);
    int off = addr % (xlen / 8);
    logic [63:0] mask, v;
    if (xlen == 32) rd[63:32] = '0;
    mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v = (rd >> (8 * off)) & mask;
    if (!f3[2] && sz < 8 && v[8 * sz - 1]) v = v | ~mask;
    if (xlen == 32) v[63:32] = '0;
    return v;
  endfunction

  function automatic logic [63:0] m_store(input int xlen, input logic [2:0] f3,
                                          input logic [63:0] wd);
    int sz = m_sz(f3);
    logic [63:0] mask, v;
    mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v = '0;
    for (int i = 0; i < xlen / 8; i += sz) v = v | ((wd & mask) << (8 * i));
    return v;
  endfunction

  // ---------------- driver (no checking) ----------------
  task automatic run_access(input bit use64, input bit wen, input logic [2:0] f3,
      input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
      input int nwait, input bit bad, output bit en_o, output int lat_o,
      output logic [63:0] rd_o, output logic [63:0] wdd_o, output bit mis_o,
      output bit flt_o, output bit rdy_o);
    lat_o = 0; rd_o = '0; wdd_o = '0; mis_o = 0; flt_o = 0; rdy_o = 0;
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    kill = 0; dmem_wait = 0; dmem_badmem_e = 0;
    #1 en_o = use64 ? b_en : a_en;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req_valid = 0; dmem_rdata = rd;
      dmem_wait = (k <= nwait); dmem_badmem_e = bad && (k > nwait);
      #1;
      if (use64 ? b_rv : a_rv) begin
        lat_o = k;
        rd_o  = use64 ? b_rd  : {32'b0, a_rd};
        wdd_o = use64 ? b_wdd : {32'b0, a_wdd};
        mis_o = use64 ? b_mis : a_mis;
        flt_o = use64 ? b_flt : a_flt;
        rdy_o = use64 ? b_ready : a_ready;
        break;
      end
      @(posedge clk);
    end
    if (lat_o != 0) @(posedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset_n = 0; req_valid = 1; req_funct3 = 3'd2; req_addr = 32'h100;
    #1;
    checks++; if ({a_ready, a_en, a_wen, a_size, a_addr, a_wdd, a_rv, a_rd, a_mis, a_flt, a_busy} !== '0) begin
      errs++; $display("FAIL reset_outputs: got ready=%b en=%b rv=%b busy=%b want all 0", a_ready, a_en, a_rv, a_busy); end
    @(negedge clk);
    reset_n = 1; req_valid = 0;
    #1;
    checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_rv !== 1'b0) begin
      errs++; $display("FAIL reset_release: got ready=%b busy=%b rv=%b want 1 0 0", a_ready, a_busy, a_rv); end
  endtask

  task automatic test_store_word();
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_funct3 = 3'd2; req_addr = 32'h100; req_wdata = 64'hDEADBEEF;
    #1;
    checks++; if ({a_en, a_wen, a_size, a_addr} !== {1'b1, 1'b1, 3'd2, 32'h100}) begin
      errs++; $display("FAIL sw_addr_phase: got en=%b wen=%b size=%0d addr=%h want 1 1 2 100", a_en, a_wen, a_size, a_addr); end
    @(negedge clk);
    req_valid = 0;
    #1;
    checks++; if (a_rv !== 1'b1 || a_wdd !== 32'hDEADBEEF || a_rd !== 32'h0) begin
      errs++; $display("FAIL sw_data_phase: got rv=%b wdd=%h rd=%h want 1 deadbeef 0", a_rv, a_wdd, a_rd); end
    @(negedge clk);
    #1;
    checks++; if (a_busy !== 1'b0 || a_rv !== 1'b0) begin
      errs++; $display("FAIL sw_idle: got busy=%b rv=%b want 0 0", a_busy, a_rv); end
  endtask

  task automatic test_load_wait();
    bit en, mis, flt, rdy; int lat; logic [63:0] rd, wdd;
    run_access(0, 0, 3'd0, 32'h103, 0, 64'h80FF_FF7F, 2, 0, en, lat, rd, wdd, mis, flt, rdy);
    checks++; if (lat !== 3) begin errs++; $display("FAIL lb_latency: got %0d want 3", lat); end
    checks++; if (rd !== 64'hFFFF_FF80) begin errs++; $display("FAIL lb_data: got %h want ffffff80", rd); end
    run_access(0, 0, 3'd4, 32'h103, 0, 64'h80FF_FF7F, 2, 0, en, lat, rd, wdd, mis, flt, rdy);
    checks++; if (lat !== 3 || rd !== 64'h80) begin errs++; $display("FAIL lbu_data: got lat=%0d rd=%h want 3 80", lat, rd); end
  endtask

  task automatic test_misaligned();
    bit en, mis, flt, rdy; int lat; logic [63:0] rd, wdd;
    run_access(0, 0, 3'd1, 32'h101, 0, 0, 0, 0, en, lat, rd, wdd, mis, flt, rdy);
    checks++; if (en !== 1'b0) begin errs++; $display("FAIL lh_mis_en: got %b want 0", en); end
    checks++; if (lat !== 1 || mis !== 1'b1 || flt !== 1'b0) begin
      errs++; $display("FAIL lh_mis_resp: got lat=%0d mis=%b flt=%b want 1 1 0", lat, mis, flt); end
    checks++; if (rdy !== 1'b0) begin errs++; $display("FAIL err_ready: got %b want 0", rdy); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_funct3 = 3'd2; req_addr = 32'h0; kill = 0; dmem_wait = 0;
    #1;
    checks++; if (a_en !== 1'b1) begin errs++; $display("FAIL b2b_first_en: got %b want 1", a_en); end
    @(negedge clk);
    req_wen = 1; req_addr = 32'h4; req_wdata = 64'hCAFE_F00D; dmem_rdata = 64'h1234_5678;
    #1;
    checks++; if (a_rv !== 1'b1 || a_rd !== 32'h1234_5678) begin
      errs++; $display("FAIL b2b_load_resp: got rv=%b rd=%h want 1 12345678", a_rv, a_rd); end
    checks++; if ({a_ready, a_en, a_wen, a_addr} !== {1'b1, 1'b1, 1'b1, 32'h4}) begin
      errs++; $display("FAIL b2b_second_addr: got ready=%b en=%b wen=%b addr=%h want 1 1 1 4", a_ready, a_en, a_wen, a_addr); end
    @(negedge clk);
    req_valid = 0;
    #1;
    checks++; if (a_rv !== 1'b1 || a_wdd !== 32'hCAFE_F00D || a_rd !== 32'h0) begin
      errs++; $display("FAIL b2b_store_resp: got rv=%b wdd=%h rd=%h want 1 cafef00d 0", a_rv, a_wdd, a_rd); end
    @(negedge clk);
    #1;
    checks++; if (a_busy !== 1'b0) begin errs++; $display("FAIL b2b_idle: got busy=%b want 0", a_busy); end
  endtask

  task automatic test_kill();
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_funct3 = 3'd2; req_addr = 32'h8; kill = 0; dmem_wait = 0;
    @(negedge clk);
    req_valid = 0; kill = 1; dmem_wait = 1;
    #1;
    checks++; if (a_rv !== 1'b0 || a_ready !== 1'b0 || a_busy !== 1'b1) begin
      errs++; $display("FAIL kill_wait: got rv=%b ready=%b busy=%b want 0 0 1", a_rv, a_ready, a_busy); end
    @(negedge clk);
    kill = 0; dmem_wait = 0; dmem_rdata = 64'h5555_5555;
    #1;
    checks++; if (a_rv !== 1'b0 || a_busy !== 1'b1) begin
      errs++; $display("FAIL kill_suppress: got rv=%b busy=%b want 0 1", a_rv, a_busy); end
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_funct3 = 3'd0; req_addr = 32'h9; kill = 1;
    #1;
    checks++; if (a_en !== 1'b0 || a_ready !== 1'b0 || a_busy !== 1'b0) begin
      errs++; $display("FAIL kill_same_cycle: got en=%b ready=%b busy=%b want 0 0 0", a_en, a_ready, a_busy); end
    @(negedge clk);
    req_valid = 0; kill = 0;
    #1;
    checks++; if (a_busy !== 1'b0 || a_rv !== 1'b0) begin
      errs++; $display("FAIL kill_no_access: got busy=%b rv=%b want 0 0", a_busy, a_rv); end
    // Store in DATA with a simultaneous kill and new request.
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 64'h1122_3344;
    @(negedge clk);
    req_wen = 0; req_addr = 32'h14; kill = 1;
    #1;
    checks++; if (a_rv !== 1'b1 || a_wdd !== 32'h1122_3344 || a_en !== 1'b0 || a_ready !== 1'b0) begin
      errs++; $display("FAIL kill_store_complete: got rv=%b wdd=%h en=%b ready=%b want 1 11223344 0 0", a_rv, a_wdd, a_en, a_ready); end
    @(negedge clk);
    req_valid = 0; kill = 0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errs++; $display("FAIL kill_store_idle: got busy=%b want 0", a_busy); end
  endtask

  task automatic test_xlen();
    bit en, mis, flt, rdy; int lat; logic [63:0] rd, wdd;
    run_access(0, 0, 3'd3, 32'h0, 0, 0, 0, 0, en, lat, rd, wdd, mis, flt, rdy);
    checks++; if (en !== 1'b0 || lat !== 1 || flt !== 1'b1 || mis !== 1'b0) begin
      errs++; $display("FAIL ld_on_x32: got en=%b lat=%0d flt=%b mis=%b want 0 1 1 0", en, lat, flt, mis); end
    run_access(1, 0, 3'd2, 32'h4, 0, 64'h8000_0000_0000_0000, 0, 0, en, lat, rd, wdd, mis, flt, rdy);
    checks++; if (rd !== 64'hFFFF_FFFF_8000_0000 || lat !== 1) begin
      errs++; $display("FAIL lw_x64_sext: got rd=%h lat=%0d want ffffffff80000000 1", rd, lat); end
  endtask

  task automatic test_badmem();
    bit en, mis, flt, rdy; int lat; logic [63:0] rd, wdd;
    run_access(0, 0, 3'd2, 32'h20, 0, 64'h1, 1, 1, en, lat, rd, wdd, mis, flt, rdy);
    checks++; if (lat !== 2 || flt !== 1'b1 || mis !== 1'b0) begin
      errs++; $display("FAIL badmem: got lat=%0d flt=%b mis=%b want 2 1 0", lat, flt, mis); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_funct3 = 3'd2; req_addr = 32'h40; kill = 0; dmem_wait = 0;
    @(negedge clk);
    req_valid = 0; dmem_wait = 1;
    @(negedge clk);
    reset_n = 0;
    #1;
    checks++; if ({a_ready, a_en, a_wen, a_size, a_addr, a_wdd, a_rv, a_rd, a_mis, a_flt, a_busy} !== '0) begin
      errs++; $display("FAIL reset_mid_outputs: got rv=%b busy=%b ready=%b want all 0", a_rv, a_busy, a_ready); end
    @(negedge clk);
    reset_n = 1; dmem_wait = 0;
    #1;
    checks++; if (a_busy !== 1'b0 || a_rv !== 1'b0) begin
      errs++; $display("FAIL reset_mid_idle: got busy=%b rv=%b want 0 0", a_busy, a_rv); end
  endtask

  task automatic test_random();
    bit en, mis, flt, rdy, use64, wen, bad, e_en, e_mis, e_flt, ill;
    int lat, nw, xl, e_lat; logic [63:0] rd, wdd, wd, rdat, e_rd, e_wdd;
    logic [2:0] f3; logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      use64 = $urandom_range(0, 1);
      wen   = $urandom_range(0, 2) == 0;
      f3    = wen ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      addr  = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      wd    = {$urandom, $urandom};
      rdat  = {$urandom, $urandom};
      nw    = $urandom_range(0, 3);
      bad   = $urandom_range(0, 5) == 0;
      xl    = use64 ? 64 : 32;
      ill   = m_ill(xl, f3);
      e_mis = !ill && m_mis(f3, addr);
      e_en  = !ill && !e_mis;
      e_flt = ill || (e_en && bad);
      e_lat = e_en ? nw + 1 : 1;
      e_rd  = (e_en && !wen) ? m_load(xl, f3, addr, rdat) : 64'h0;
      e_wdd = (e_en && wen) ? m_store(xl, f3, wd) : 64'h0;
      run_access(use64, wen, f3, addr, wd, rdat, nw, bad, en, lat, rd, wdd, mis, flt, rdy);
      checks++; if (en !== e_en) begin errs++; $display("FAIL rnd%0d_en: got %b want %b", n, en, e_en); end
      checks++; if (lat !== e_lat) begin errs++; $display("FAIL rnd%0d_lat: got %0d want %0d", n, lat, e_lat); end
      checks++; if (rd !== e_rd) begin errs++; $display("FAIL rnd%0d_rdata: got %h want %h", n, rd, e_rd); end
      checks++; if (wdd !== e_wdd) begin errs++; $display("FAIL rnd%0d_wdata: got %h want %h", n, wdd, e_wdd); end
      checks++; if (mis !== e_mis || flt !== e_flt) begin
        errs++; $display("FAIL rnd%0d_err: got mis=%b flt=%b want %b %b", n, mis, flt, e_mis, e_flt); end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_wait();
    test_misaligned();
    test_back_to_back();
    test_kill();
    test_xlen();
    test_badmem();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
